pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: number of cycles pll_rst is held high per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 125000: maximum number of WAIT_LOCK cycles (1 ms at 125 MHz) before an attempt fails.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synced-lock cycles required before the clock is declared ready.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: number of consecutive failed attempts before FAULT (min 1).
REQ-005 SHALL have port refclk, input, 1: free-running reference clock; the single clock of the block.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1: single-cycle synchronous request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-010 SHALL have port clk_ready, output, 1: high only while in RUN.
REQ-011 SHALL have port fault, output, 1: high only while in FAULT.
REQ-012 SHALL have port relock_count, output, 8: saturating count of lock losses seen in RUN.
REQ-013 SHALL have port state, output, 3: current FSM state encoding, for debug.

Function
REQ-014 SHALL synchronize pll_locked through two flops (lk_s); all decisions use lk_s, giving 2 cycles of input latency.
REQ-015 SHALL implement states HOLD, WAIT_LOCK, STABLE, RUN and FAULT, with all outputs registered.
REQ-016 HOLD SHALL drive pll_rst=1 for exactly RST_HOLD_CYCLES cycles, then enter WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL drive pll_rst=0; lk_s=1 SHALL enter STABLE; otherwise the block SHALL count, and on LOCK_TIMEOUT elapsed cycles SHALL increment the retry count.
REQ-018 On timeout, the block SHALL enter FAULT if the incremented retry count equals MAX_RETRIES, else HOLD.
REQ-019 STABLE SHALL enter RUN after LOCK_STABLE_CYCLES consecutive cycles with lk_s=1; lk_s=0 SHALL return to WAIT_LOCK with the timeout counter cleared and the retry count unchanged.
REQ-020 Entering RUN SHALL clear the retry count; clk_ready SHALL be 1 on the first RUN cycle.
REQ-021 In RUN, lk_s=0 SHALL go to HOLD and increment relock_count, saturating at 255; clk_ready SHALL be 0 from the first HOLD cycle.
REQ-022 FAULT SHALL hold pll_rst=1 and fault=1 and be left only by restart or reset.
REQ-023 restart SHALL force HOLD from any state with the retry count cleared; relock_count SHALL be unchanged.
REQ-024 restart SHALL take priority over a simultaneous timeout, lock loss or stable completion.

Reset
REQ-025 While rst_n=0, state SHALL be HOLD, pll_rst=1, clk_ready=0, fault=0, relock_count=0, and all counters and sync flops SHALL be 0.
REQ-026 After rst_n release, the HOLD count SHALL start at 0, so pll_rst stays high for RST_HOLD_CYCLES further cycles.
REQ-027 Reset assertion mid-sequence SHALL abort immediately, asynchronously.

Configuration
REQ-028 With PLL_SEQ_STATUS_EN defined, relock_count SHALL be implemented per REQ-021.
REQ-029 Without PLL_SEQ_STATUS_EN, relock_count SHALL be constant 0 with no counter logic; all other behaviour SHALL be identical.

Structure
REQ-030 The shared package pll_seq_pkg SHALL hold the state enum (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4) and the relock_count width constant (8).
REQ-031 The lock synchronizer SHALL be the sub-module sync_2ff; counters and the FSM SHALL be in pll_lock_sequencer.

Verification (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-032 Nominal: rst_n release, pll_locked high at cycle 10 -> pll_rst high cycles 0-3; clk_ready rises at cycle 10+2+8=20.
REQ-033 Never lock: pll_locked=0 -> three HOLD/WAIT_LOCK attempts, then fault=1, pll_rst=1, state=4; restart -> HOLD, fault=0.
REQ-034 Lock glitch: pll_locked low 1 cycle during STABLE -> WAIT_LOCK, then STABLE restarts its full 8-cycle count, no retry increment, clk_ready delayed accordingly.
REQ-035 Lock loss in RUN 300 times -> relock_count=255 (saturated), each loss re-enters HOLD with clk_ready=0; with macro undefined -> relock_count=0.
REQ-036 restart in the same cycle as a WAIT_LOCK timeout on the third attempt -> HOLD (not FAULT), retry count 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

  localparam int RELOCK_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the local clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: HOLD -> WAIT_LOCK -> STABLE -> RUN with retry limit and FAULT.
// Define PLL_SEQ_STATUS_EN to build the saturating relock_count counter; otherwise it reads 0.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 125000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                restart,
  output logic                pll_rst,
  output logic                clk_ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [2:0]          state
);

  localparam int CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  logic               lk_s;
  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, clk_ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // One shared counter: hold length, lock timeout or stable run, depending on state.
  // The WAIT_LOCK cycle that first sees lk_s counts as the first stable cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            if (LOCK_STABLE_CYCLES <= 1) begin
              state_d = RUN;
              cnt_d   = '0;
              retry_d = '0;
            end else begin
              state_d = STABLE;
              cnt_d   = CNT_W'(1);
            end
          end else if (cnt_q == TMO_LAST) begin
            cnt_d   = '0;
            retry_d = retry_q + RETRY_W'(1);
            state_d = (retry_q == RETRY_LAST) ? FAULT : HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STAB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == HOLD) || (state_d == FAULT);
      clk_ready_q <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign clk_ready = clk_ready_q;
  assign fault     = fault_q;
  assign state     = state_q;

`ifdef PLL_SEQ_STATUS_EN
  logic                lock_lost;
  logic [RELOCK_W-1:0] relock_q;

  assign lock_lost = (state_q == RUN) && !lk_s && !restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else if (lock_lost && (relock_q != '1)) begin
      relock_q <= relock_q + RELOCK_W'(1);
    end
  end

  assign relock_count = relock_q;
`else
  assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: expected state transitions (with cycle stamps) are queued by stimulus and popped by a monitor.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int RH = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, clk_ready, fault;
  logic [7:0] relock_count;
  logic [2:0] state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int losses = 0;
  int prev_state = 7;

  typedef struct {
    int st;
    int rst;
    int rdy;
    int flt;
    int rc;
    int cyc;
  } exp_t;

  exp_t sbq[$];

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (RH),
    .LOCK_TIMEOUT       (TO),
    .LOCK_STABLE_CYCLES (ST),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .clk_ready    (clk_ready),
    .fault        (fault),
    .relock_count (relock_count),
    .state        (state)
  );

  initial forever #5 refclk = ~refclk;

  // Cycle 0 is the period right after reset release.
  always @(posedge refclk) cyc <= rst_n ? cyc + 1 : 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue holds %0d entries", sbq.size());
    $fatal(1, "watchdog");
  end

  function automatic int rc_model(input int n);
`ifdef PLL_SEQ_STATUS_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int st, input int r, input int rd, input int f, input int c);
    exp_t e;
    e.st  = st;
    e.rst = r;
    e.rdy = rd;
    e.flt = f;
    e.rc  = rc_model(losses);
    e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp, input int at);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, at);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge refclk);
  endtask

  // Monitor: every state change is a DUT presentation checked against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (int'(state) != prev_state) begin
        prev_state = int'(state);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition: got state %0d, expected no transition (cycle %0d)", state, cyc);
        end else begin
          e = sbq.pop_front();
          chk("state", int'(state), e.st, cyc);
          chk("pll_rst", int'(pll_rst), e.rst, cyc);
          chk("clk_ready", int'(clk_ready), e.rdy, cyc);
          chk("fault", int'(fault), e.flt, cyc);
          chk("relock_count", int'(relock_count), e.rc, cyc);
          if (e.cyc >= 0) chk("transition_cycle", cyc, e.cyc, cyc);
        end
      end
    end
  end

  initial begin
    int c;
    push(HOLD, 1, 0, 0, -1);
    #3 rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    rst_n = 1'b1;

    // Nominal lock: pll_locked at cycle 10, ready at 10+2+8.
    push(WAIT_LOCK, 0, 0, 0, 4);
    push(STABLE, 0, 0, 0, 13);
    push(RUN, 0, 1, 0, 20);
    wait_cyc(10); pll_locked = 1'b1;

    // Lock loss in RUN, then a one-cycle glitch during STABLE.
    wait_cyc(30);
    losses = 1;
    push(HOLD, 1, 0, 0, 33);
    push(WAIT_LOCK, 0, 0, 0, 37);
    push(STABLE, 0, 0, 0, 43);
    push(WAIT_LOCK, 0, 0, 0, 48);
    push(STABLE, 0, 0, 0, 49);
    push(RUN, 0, 1, 0, 56);
    pll_locked = 1'b0;
    wait_cyc(40); pll_locked = 1'b1;
    wait_cyc(45); pll_locked = 1'b0;
    wait_cyc(46); pll_locked = 1'b1;

    // Restart from RUN, then never lock: three attempts then FAULT.
    wait_cyc(60);
    push(HOLD, 1, 0, 0, 61);
    push(WAIT_LOCK, 0, 0, 0, 65);
    push(HOLD, 1, 0, 0, 85);
    push(WAIT_LOCK, 0, 0, 0, 89);
    push(HOLD, 1, 0, 0, 109);
    push(WAIT_LOCK, 0, 0, 0, 113);
    push(FAULT, 1, 0, 1, 133);
    restart = 1'b1; pll_locked = 1'b0;
    wait_cyc(61); restart = 1'b0;

    // Restart out of FAULT; a restart coinciding with the third timeout wins.
    wait_cyc(140);
    push(HOLD, 1, 0, 0, 141);
    push(WAIT_LOCK, 0, 0, 0, 145);
    push(HOLD, 1, 0, 0, 165);
    push(WAIT_LOCK, 0, 0, 0, 169);
    push(HOLD, 1, 0, 0, 189);
    push(WAIT_LOCK, 0, 0, 0, 193);
    push(HOLD, 1, 0, 0, 213);
    push(WAIT_LOCK, 0, 0, 0, 217);
    push(HOLD, 1, 0, 0, 237);
    push(WAIT_LOCK, 0, 0, 0, 241);
    push(HOLD, 1, 0, 0, 261);
    push(WAIT_LOCK, 0, 0, 0, 265);
    push(FAULT, 1, 0, 1, 285);
    restart = 1'b1;
    wait_cyc(141); restart = 1'b0;
    wait_cyc(212); restart = 1'b1;
    wait_cyc(213); restart = 1'b0;

    // Recover, then 300 lock losses in RUN to saturate relock_count.
    wait_cyc(290);
    push(HOLD, 1, 0, 0, 291);
    push(WAIT_LOCK, 0, 0, 0, 295);
    push(STABLE, 0, 0, 0, 296);
    push(RUN, 0, 1, 0, 303);
    restart = 1'b1;
    wait_cyc(291); restart = 1'b0; pll_locked = 1'b1;

    c = 303;
    for (int i = 0; i < 300; i++) begin
      wait_cyc(c);
      losses++;
      push(HOLD, 1, 0, 0, c + 3);
      push(WAIT_LOCK, 0, 0, 0, c + 7);
      push(STABLE, 0, 0, 0, c + 8);
      push(RUN, 0, 1, 0, c + 15);
      pll_locked = 1'b0;
      wait_cyc(c + 3); pll_locked = 1'b1;
      c = c + 15;
    end

    // Asynchronous reset mid-RUN aborts to HOLD and clears relock_count.
    wait_cyc(c + 2);
    #2;
    losses = 0;
    push(HOLD, 1, 0, 0, -1);
    rst_n = 1'b0;
    repeat (4) @(negedge refclk);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge refclk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_transitions: got %0d left in queue, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
